// File: rtl/mem_block_responder.sv
// Purpose: bottom-of-hierarchy backing store; serves one RETURN_SIZE block per level-held request.
// Latency: completion flag first high in the cycle after edge E0+MEM_DELAY (E0 = accepting edge).
// Backpressure: requester holds enableIn until it sees completion; the flag holds until enableIn drops.
module mem_block_responder #(
  parameter int SIZE        = 2048,
  parameter int ADDR_LENGTH = 11,
  parameter int RETURN_SIZE = 128,
  parameter int MEM_DELAY   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_LENGTH-1:0] addrIn,
  output logic [RETURN_SIZE-1:0] dataUpOut,
  input  logic [RETURN_SIZE-1:0] dataUpIn,
  output logic                   fetchComplete,
  input  logic                   enableIn,
  output logic                   writeCompleteOut,
  input  logic                   writeIn
);

  localparam int WPB  = RETURN_SIZE / 32;
  localparam int IW   = $clog2(SIZE);
  localparam int CW   = $clog2(MEM_DELAY) + 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_DELAY - 1);
  // Clears the word-within-block bits so any address maps to its block base.
  localparam logic [ADDR_LENGTH-1:0] BLK_MASK = ~(ADDR_LENGTH'(WPB - 1));

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state, next_state;
  logic [CW-1:0]            counter;
  logic [ADDR_LENGTH-1:0]   base_q;
  logic                     wr_q;
  logic [RETURN_SIZE-1:0]   dat_q;
  logic [31:0]              mem [SIZE];

  logic                     accept, access, finish;
  logic [63:0]              end_addr;
  logic                     in_range;
  logic [IW-1:0]            idx;
  logic [RETURN_SIZE-1:0]   rd_blk;

  // Range check and read mux work only from latched request values.
  always_comb begin
    end_addr = 64'(base_q) + 64'(WPB);
    in_range = (end_addr <= 64'(SIZE));
    idx      = IW'(base_q);
    rd_blk   = '0;
    for (int w = 0; w < WPB; w++) begin
      if (in_range) rd_blk[w*32 +: 32] = mem[idx + IW'(w)];
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and event decode; dropping enableIn in BUSY aborts without access.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    access     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (enableIn) begin
        next_state = BUSY;
        accept     = 1'b1;
      end
      BUSY: if (!enableIn) begin
        next_state = IDLE;
      end else if (counter == LAST) begin
        next_state = DONE;
        access     = 1'b1;
      end
      DONE: if (!enableIn) begin
        next_state = IDLE;
        finish     = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch, delay counter, storage access and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      counter          <= '0;
      base_q           <= '0;
      wr_q             <= 1'b0;
      dat_q            <= '0;
      dataUpOut        <= '0;
      fetchComplete    <= 1'b0;
      writeCompleteOut <= 1'b0;
      for (int i = 0; i < SIZE; i++) mem[i] <= 32'(i);
    end else begin
      if (accept) begin
        base_q  <= addrIn & BLK_MASK;
        wr_q    <= writeIn;
        dat_q   <= dataUpIn;
        counter <= '0;
      end else if (state == BUSY) begin
        counter <= counter + CW'(1);
      end
      if (access) begin
        if (wr_q) begin
          // Out-of-range writes are dropped but still acknowledged.
          if (in_range) begin
            for (int w = 0; w < WPB; w++) mem[idx + IW'(w)] <= dat_q[w*32 +: 32];
          end
          writeCompleteOut <= 1'b1;
        end else begin
          dataUpOut     <= rd_blk;
          fetchComplete <= 1'b1;
        end
      end
      if (finish) begin
        dataUpOut        <= '0;
        fetchComplete    <= 1'b0;
        writeCompleteOut <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed bench for mem_block_responder with default parameters.
// Each scenario task drives stimulus and compares against hand-computed blocks.
module tb_mem_block_responder;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [10:0]  addrIn = '0;
  logic [127:0] dataUpOut;
  logic [127:0] dataUpIn = '0;
  logic         fetchComplete;
  logic         enableIn = 1'b0;
  logic         writeCompleteOut;
  logic         writeIn = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [127:0] BLK0  = 128'h00000003_00000002_00000001_00000000;
  localparam logic [127:0] BLK4  = 128'h00000007_00000006_00000005_00000004;
  localparam logic [127:0] BLK12 = 128'h0000000F_0000000E_0000000D_0000000C;
  localparam logic [127:0] BLK16 = 128'h00000013_00000012_00000011_00000010;
  localparam logic [127:0] BLK20 = 128'h00000017_00000016_00000015_00000014;
  localparam logic [127:0] BLK28 = 128'h0000001F_0000001E_0000001D_0000001C;
  localparam logic [127:0] ONES  = {128{1'b1}};
  localparam logic [127:0] PAT   = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;

  mem_block_responder dut (
    .clock(clock), .reset(reset), .addrIn(addrIn), .dataUpOut(dataUpOut),
    .dataUpIn(dataUpIn), .fetchComplete(fetchComplete), .enableIn(enableIn),
    .writeCompleteOut(writeCompleteOut), .writeIn(writeIn)
  );

  always #5 clock = ~clock;

  // Advance past one rising edge; outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a request and count edges after the accepting edge until a flag rises (bounded).
  task automatic run_req(input logic wr, input logic [10:0] addr, input logic [127:0] dat,
                         output int lat);
    enableIn = 1'b1; writeIn = wr; addrIn = addr; dataUpIn = dat;
    tick();
    lat = 0;
    while (!(fetchComplete || writeCompleteOut) && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_req();
    enableIn = 1'b0; writeIn = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (fetchComplete !== 1'b0) $display("FAIL reset_fetch got=%b exp=0", fetchComplete); else n_pass++;
    n_checks++; if (writeCompleteOut !== 1'b0) $display("FAIL reset_wc got=%b exp=0", writeCompleteOut); else n_pass++;
    n_checks++; if (dataUpOut !== 128'h0) $display("FAIL reset_data got=%h exp=0", dataUpOut); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_read_latency();
    enableIn = 1'b1; writeIn = 1'b0; addrIn = 11'd0;
    tick(); // E0
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (fetchComplete !== 1'b0) $display("FAIL early_fetch edge=E0+%0d got=%b exp=0", k, fetchComplete); else n_pass++;
    end
    tick(); // E0+4
    n_checks++; if (fetchComplete !== 1'b1) $display("FAIL fetch_at_e4 got=%b exp=1", fetchComplete); else n_pass++;
    n_checks++; if (dataUpOut !== BLK0) $display("FAIL read0_data got=%h exp=%h", dataUpOut, BLK0); else n_pass++;
    n_checks++; if (writeCompleteOut !== 1'b0) $display("FAIL read0_wc got=%b exp=0", writeCompleteOut); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (fetchComplete !== 1'b1 || dataUpOut !== BLK0)
        $display("FAIL hold_stable cyc=%0d got=%b/%h exp=1/%h", k, fetchComplete, dataUpOut, BLK0);
      else n_pass++;
    end
    release_req();
    n_checks++; if (fetchComplete !== 1'b0) $display("FAIL drop_fetch got=%b exp=0", fetchComplete); else n_pass++;
    n_checks++; if (dataUpOut !== 128'h0) $display("FAIL drop_data got=%h exp=0", dataUpOut); else n_pass++;
  endtask

  task automatic test_read_aligned();
    int lat;
    run_req(1'b0, 11'd5, '0, lat);
    n_checks++; if (lat !== 4) $display("FAIL read5_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (dataUpOut !== BLK4) $display("FAIL read5_data got=%h exp=%h", dataUpOut, BLK4); else n_pass++;
    release_req();
  endtask

  task automatic test_write();
    int lat;
    run_req(1'b1, 11'd8, ONES, lat);
    n_checks++; if (lat !== 4) $display("FAIL write8_latency got=%0d exp=4", lat); else n_pass++;
    n_checks++; if (writeCompleteOut !== 1'b1) $display("FAIL write8_wc got=%b exp=1", writeCompleteOut); else n_pass++;
    n_checks++; if (fetchComplete !== 1'b0) $display("FAIL write8_fetch got=%b exp=0", fetchComplete); else n_pass++;
    release_req();
    n_checks++; if (writeCompleteOut !== 1'b0) $display("FAIL write8_drop got=%b exp=0", writeCompleteOut); else n_pass++;
    run_req(1'b0, 11'd9, '0, lat);
    n_checks++; if (dataUpOut !== ONES) $display("FAIL read9_data got=%h exp=%h", dataUpOut, ONES); else n_pass++;
    release_req();
    run_req(1'b0, 11'd12, '0, lat);
    n_checks++; if (dataUpOut !== BLK12) $display("FAIL read12_data got=%h exp=%h", dataUpOut, BLK12); else n_pass++;
    release_req();
  endtask

  task automatic test_abort();
    int flags;
    int lat;
    enableIn = 1'b1; writeIn = 1'b1; addrIn = 11'd16; dataUpIn = PAT;
    tick(); // E0
    tick();
    enableIn = 1'b0;
    flags = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (fetchComplete || writeCompleteOut) flags++;
    end
    n_checks++; if (flags !== 0) $display("FAIL abort_pulse got=%0d exp=0", flags); else n_pass++;
    run_req(1'b0, 11'd16, '0, lat);
    n_checks++; if (dataUpOut !== BLK16) $display("FAIL abort_read16 got=%h exp=%h", dataUpOut, BLK16); else n_pass++;
    release_req();
  endtask

  task automatic test_input_ignore();
    int lat;
    enableIn = 1'b1; writeIn = 1'b1; addrIn = 11'd24; dataUpIn = PAT;
    tick(); // E0 latches the write
    writeIn = 1'b0; addrIn = 11'd28; dataUpIn = ONES;
    lat = 0;
    while (!(fetchComplete || writeCompleteOut) && lat < 40) begin
      tick();
      lat++;
    end
    n_checks++; if (writeCompleteOut !== 1'b1 || fetchComplete !== 1'b0)
      $display("FAIL latched_kind got=wc%b/fc%b exp=wc1/fc0", writeCompleteOut, fetchComplete); else n_pass++;
    release_req();
    run_req(1'b0, 11'd24, '0, lat);
    n_checks++; if (dataUpOut !== PAT) $display("FAIL read24_data got=%h exp=%h", dataUpOut, PAT); else n_pass++;
    release_req();
    run_req(1'b0, 11'd28, '0, lat);
    n_checks++; if (dataUpOut !== BLK28) $display("FAIL read28_data got=%h exp=%h", dataUpOut, BLK28); else n_pass++;
    release_req();
  endtask

  task automatic test_rearm();
    int lat;
    int held;
    int flags;
    run_req(1'b0, 11'd20, '0, lat);
    n_checks++; if (lat !== 4) $display("FAIL rearm_latency got=%0d exp=4", lat); else n_pass++;
    held = 0;
    for (int k = 0; k < 20; k++) begin
      if (k == 5) addrIn = 11'd0;
      tick();
      if (fetchComplete === 1'b1 && writeCompleteOut === 1'b0 && dataUpOut === BLK20) held++;
    end
    n_checks++; if (held !== 20) $display("FAIL rearm_hold got=%0d exp=20", held); else n_pass++;
    release_req();
    flags = 0;
    for (int k = 0; k < 6; k++) begin
      if (fetchComplete || writeCompleteOut) flags++;
      tick();
    end
    n_checks++; if (flags !== 0) $display("FAIL rearm_extra got=%0d exp=0", flags); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat;
    run_req(1'b1, 11'd0, ONES, lat);
    n_checks++; if (writeCompleteOut !== 1'b1) $display("FAIL mid_w0_wc got=%b exp=1", writeCompleteOut); else n_pass++;
    release_req();
    enableIn = 1'b1; writeIn = 1'b1; addrIn = 11'd4; dataUpIn = '0;
    tick(); // E0
    tick(); // in BUSY
    reset = 1'b1;
    tick();
    n_checks++; if (fetchComplete !== 1'b0 || writeCompleteOut !== 1'b0 || dataUpOut !== 128'h0)
      $display("FAIL mid_reset_out got=%b/%b/%h exp=0/0/0", fetchComplete, writeCompleteOut, dataUpOut); else n_pass++;
    reset = 1'b0; enableIn = 1'b0; writeIn = 1'b0;
    tick();
    run_req(1'b0, 11'd0, '0, lat);
    n_checks++; if (dataUpOut !== BLK0) $display("FAIL mid_read0 got=%h exp=%h", dataUpOut, BLK0); else n_pass++;
    release_req();
    run_req(1'b0, 11'd4, '0, lat);
    n_checks++; if (dataUpOut !== BLK4) $display("FAIL mid_read4 got=%h exp=%h", dataUpOut, BLK4); else n_pass++;
    release_req();
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_read_aligned();
    test_write();
    test_abort();
    test_input_ignore();
    test_rearm();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
